// File: rtl/rv32i_instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word behind a 2-entry output skid buffer.
// Optional macro IMM_RANGE_CHECK_EN flags immediates that do not fit their format.
module rv32i_instr_encoder #(
  parameter int ADDR_W   = 10,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          fmt,
  input  logic [6:0]          opcode,
  input  logic [4:0]          rd,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic [31:0]         imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                out_err,
  input  logic                addr_clr,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] enc_instr;
  logic        enc_err;

`ifdef IMM_RANGE_CHECK_EN
  logic signed [31:0] imm_s;
  assign imm_s = imm;
`endif

  always_comb begin
    enc_instr = NOP;
    enc_err   = 1'b0;
    case (fmt)
      3'd0: enc_instr = {funct7, rs2, rs1, funct3, rd, opcode};
      3'd1: enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
      3'd2: enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      3'd3: enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      3'd4: enc_instr = {imm[31:12], rd, opcode};
      3'd5: enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: begin
        enc_instr = NOP;
        enc_err   = 1'b1;
      end
    endcase
`ifdef IMM_RANGE_CHECK_EN
    // The word is still built from the truncated bits; only the flag changes.
    case (fmt)
      3'd1, 3'd2: if (imm_s < -32'sd2048 || imm_s > 32'sd2047) enc_err = 1'b1;
      3'd3: if (imm_s < -32'sd4096 || imm_s > 32'sd4094 || imm[0]) enc_err = 1'b1;
      3'd4: if (imm[11:0] != 12'd0) enc_err = 1'b1;
      3'd5: if (imm_s < -32'sd1048576 || imm_s > 32'sd1048574 || imm[0]) enc_err = 1'b1;
      default: ;
    endcase
`endif
  end

  logic                head_valid_reg, head_valid_next;
  logic [31:0]         head_instr_reg, head_instr_next;
  logic                head_err_reg, head_err_next;
  logic                skid_valid_reg, skid_valid_next;
  logic [31:0]         skid_instr_reg, skid_instr_next;
  logic                skid_err_reg, skid_err_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [ERRCNT_W-1:0] err_cnt_reg, err_cnt_next;
  logic                push, pop;

  assign in_ready  = ~skid_valid_reg;
  assign out_valid = head_valid_reg;
  assign out_instr = head_instr_reg;
  assign out_err   = head_err_reg;
  assign out_addr  = addr_reg;
  assign err_cnt   = err_cnt_reg;

  assign push = in_valid & in_ready;
  assign pop  = head_valid_reg & out_ready;

  always_comb begin
    head_valid_next = head_valid_reg;
    head_instr_next = head_instr_reg;
    head_err_next   = head_err_reg;
    skid_valid_next = skid_valid_reg;
    skid_instr_next = skid_instr_reg;
    skid_err_next   = skid_err_reg;
    if (pop) begin
      // A full skid blocks pushes, so pop-with-skid is a plain shift forward.
      if (skid_valid_reg) begin
        head_instr_next = skid_instr_reg;
        head_err_next   = skid_err_reg;
        skid_valid_next = 1'b0;
      end else if (push) begin
        head_instr_next = enc_instr;
        head_err_next   = enc_err;
      end else begin
        head_valid_next = 1'b0;
      end
    end else if (push) begin
      if (!head_valid_reg) begin
        head_valid_next = 1'b1;
        head_instr_next = enc_instr;
        head_err_next   = enc_err;
      end else begin
        skid_valid_next = 1'b1;
        skid_instr_next = enc_instr;
        skid_err_next   = enc_err;
      end
    end
  end

  always_comb begin
    addr_next    = addr_reg;
    err_cnt_next = err_cnt_reg;
    if (addr_clr)
      addr_next = '0;
    else if (pop)
      addr_next = addr_reg + 1'b1;
    if (pop && head_err_reg && err_cnt_reg != '1)
      err_cnt_next = err_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid_reg <= 1'b0;
      head_instr_reg <= '0;
      head_err_reg   <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_instr_reg <= '0;
      skid_err_reg   <= 1'b0;
      addr_reg       <= '0;
      err_cnt_reg    <= '0;
    end else begin
      head_valid_reg <= head_valid_next;
      head_instr_reg <= head_instr_next;
      head_err_reg   <= head_err_next;
      skid_valid_reg <= skid_valid_next;
      skid_instr_reg <= skid_instr_next;
      skid_err_reg   <= skid_err_next;
      addr_reg       <= addr_next;
      err_cnt_reg    <= err_cnt_next;
    end
  end

endmodule
